// File: rtl/adc_capture_mem_arbiter_if.sv
// Bus bundle for the capture arbiter: the Nios Avalon-MM slave side and the
// sample memory s1 side. The arbiter uses 'slave'; the environment uses 'master'.
interface adc_capture_mem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              cpu_chipselect;
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [3:0]        cpu_byteenable;
    logic [DATA_W-1:0] cpu_writedata;
    logic [DATA_W-1:0] cpu_readdata;
    logic              cpu_readdatavalid;
    logic              cpu_waitrequest;

    logic              mem_chipselect;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_clken;

    modport slave (
        input  cpu_chipselect, cpu_read, cpu_write, cpu_address, cpu_byteenable, cpu_writedata,
        output cpu_readdata, cpu_readdatavalid, cpu_waitrequest,
        output mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output cpu_chipselect, cpu_read, cpu_write, cpu_address, cpu_byteenable, cpu_writedata,
        input  cpu_readdata, cpu_readdatavalid, cpu_waitrequest,
        input  mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/adc_capture_mem_arbiter.sv
// Capture sequencer and single-port memory arbiter between the ADC sample
// stream and the Nios data master.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no run active; CPU has the memory whenever it asks
// ST_CAPTURE | run active; ADC samples held and written to wr_ptr
// ST_DONE    | run finished (done sticky); CPU access only
module adc_capture_mem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm_i,
    input  logic                     abort_i,
    input  logic [ADDR_W:0]          num_samples_i,
    input  logic                     adc_valid_i,
    input  logic [DATA_W-1:0]        adc_data_i,
    adc_capture_mem_arbiter_if.slave bus,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overrun_o,
    output logic [ADDR_W-1:0]        wr_ptr_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_N   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0]   hold_data_q, hold_data_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                rdv_q, rdv_d;
    logic                last_adc_q, last_adc_d;

    logic                cpu_req;
    logic                grant_adc;
    logic                grant_cpu;
    logic                final_grant;
    logic [ADDR_W:0]     target;

    // Arbitration: ADC by default, CPU gets the slot right after an ADC write.
    // Requests are masked while reset is held so the memory and CPU see an idle bus.
    always_comb begin
        cpu_req     = bus.cpu_chipselect & (bus.cpu_read | bus.cpu_write) & ~reset;
        grant_adc   = hold_valid_q & ~(cpu_req & last_adc_q);
        grant_cpu   = cpu_req & ~grant_adc;
        target      = ((num_samples_i == '0) || (num_samples_i > DEPTH_N)) ? DEPTH_N : num_samples_i;
        final_grant = grant_adc & ((count_q + CNT_ONE) == target);
    end

    // Next-state: run sequencing, sample hold, pointer/count and grant history.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        done_d       = done_q;
        overrun_d    = overrun_q;
        last_adc_d   = last_adc_q;
        rdv_d        = grant_cpu & bus.cpu_read;

        if (grant_adc) begin
            wr_ptr_d   = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + PTR_ONE;
            count_d    = count_q + CNT_ONE;
            last_adc_d = 1'b1;
        end else if (grant_cpu) begin
            last_adc_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_i && !abort_i) begin
                    state_d      = ST_CAPTURE;
                    wr_ptr_d     = '0;
                    count_d      = '0;
                    done_d       = 1'b0;
                    overrun_d    = 1'b0;
                    hold_valid_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (abort_i) begin
                    state_d      = ST_IDLE;
                    hold_valid_d = 1'b0;
                end else if (final_grant) begin
                    // the sample arriving alongside the last write is not part of the run
                    state_d      = ST_DONE;
                    done_d       = 1'b1;
                    hold_valid_d = 1'b0;
                end else if (adc_valid_i) begin
                    if (!hold_valid_q || grant_adc) begin
                        hold_valid_d = 1'b1;
                        hold_data_d  = adc_data_i;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (grant_adc) begin
                    hold_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            rdv_q        <= 1'b0;
            last_adc_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            rdv_q        <= rdv_d;
            last_adc_q   <= last_adc_d;
        end
    end

    // Memory port mux: ADC write, CPU pass-through, or idle.
    always_comb begin
        bus.mem_chipselect = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = '0;
        bus.mem_byteenable = '0;
        bus.mem_writedata  = '0;
        if (grant_adc) begin
            bus.mem_chipselect = 1'b1;
            bus.mem_write      = 1'b1;
            bus.mem_address    = wr_ptr_q;
            bus.mem_byteenable = 4'hF;
            bus.mem_writedata  = hold_data_q;
        end else if (grant_cpu) begin
            bus.mem_chipselect = 1'b1;
            bus.mem_write      = bus.cpu_write;
            bus.mem_address    = bus.cpu_address;
            bus.mem_byteenable = bus.cpu_byteenable;
            bus.mem_writedata  = bus.cpu_writedata;
        end
    end

    assign bus.cpu_waitrequest   = cpu_req & ~grant_cpu;
    assign bus.cpu_readdatavalid = rdv_q;
    assign bus.cpu_readdata      = rdv_q ? bus.mem_readdata : '0;
    assign bus.mem_clken         = 1'b1;

    assign busy_o    = (state_q == ST_CAPTURE);
    assign done_o    = done_q;
    assign overrun_o = overrun_q;
    assign wr_ptr_o  = wr_ptr_q;
endmodule

// File: tb/tb_adc_capture_mem_arbiter.sv
// Directed bench for adc_capture_mem_arbiter with a behavioural 2048x32
// single-port memory (registered read, byte-enabled write).
module tb_adc_capture_mem_arbiter;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              arm;
    logic              abort;
    logic [ADDR_W:0]   num_samples;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic              busy;
    logic              done;
    logic              overrun;
    logic [ADDR_W-1:0] wr_ptr;

    int checks = 0;
    int errors = 0;

    adc_capture_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    adc_capture_mem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .arm_i         (arm),
        .abort_i       (abort),
        .num_samples_i (num_samples),
        .adc_valid_i   (adc_valid),
        .adc_data_i    (adc_data),
        .bus           (bus),
        .busy_o        (busy),
        .done_o        (done),
        .overrun_o     (overrun),
        .wr_ptr_o      (wr_ptr)
    );

    always #5 clk = ~clk;

    // memory model
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_q;
    int                wr_count = 0;

    always @(posedge clk) begin
        if (bus.mem_chipselect && bus.mem_write) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_byteenable[b]) mem[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
            wr_count <= wr_count + 1;
        end
        if (bus.mem_chipselect && !bus.mem_write) rd_q <= mem[bus.mem_address];
    end
    assign bus.mem_readdata = rd_q;

    task automatic test_reset();
        reset = 1'b1; arm = 1'b0; abort = 1'b0; num_samples = '0; adc_valid = 1'b0; adc_data = '0;
        bus.cpu_chipselect = 1'b0; bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
        bus.cpu_address = '0; bus.cpu_byteenable = 4'hF; bus.cpu_writedata = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0h exp 0", done); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0h exp 0", overrun); end
        checks++; if (wr_ptr !== 11'd0) begin errors++; $display("FAIL reset_wr_ptr got %0h exp 0", wr_ptr); end
        checks++; if (bus.cpu_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv got %0h exp 0", bus.cpu_readdatavalid); end
        checks++; if (bus.mem_chipselect !== 1'b0) begin errors++; $display("FAIL reset_mem_cs got %0h exp 0", bus.mem_chipselect); end
        checks++; if (bus.mem_clken !== 1'b1) begin errors++; $display("FAIL reset_clken got %0h exp 1", bus.mem_clken); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0h exp 0", busy); end
    endtask

    task automatic test_capture8();
        int start;
        start = wr_count;
        @(negedge clk); arm = 1'b1; num_samples = 12'd8;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); arm = 1'b0; adc_valid = 1'b1; adc_data = 32'(i);
        end
        @(negedge clk); adc_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL cap8_last busy=%0h done=%0h exp busy=1 done=0", busy, done); end
        checks++; if (bus.mem_chipselect !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_address !== 11'd7 || bus.mem_writedata !== 32'd7)
            begin errors++; $display("FAIL cap8_final_write cs=%0h we=%0h addr=%0d data=%0h exp 1 1 7 7", bus.mem_chipselect, bus.mem_write, bus.mem_address, bus.mem_writedata); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL cap8_done got %0h exp 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cap8_busy got %0h exp 0", busy); end
        checks++; if (wr_ptr !== 11'd8) begin errors++; $display("FAIL cap8_wr_ptr got %0d exp 8", wr_ptr); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL cap8_overrun got %0h exp 0", overrun); end
        checks++; if (wr_count - start != 8) begin errors++; $display("FAIL cap8_writes got %0d exp 8", wr_count - start); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (mem[k] !== 32'(k)) begin errors++; $display("FAIL cap8_mem[%0d] got %0h exp %0h", k, mem[k], k); end
        end
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        bus.cpu_chipselect = 1'b1; bus.cpu_read = 1'b1; bus.cpu_address = 11'd5; bus.cpu_byteenable = 4'hF;
        #1;
        checks++; if (bus.cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL rd_wait got %0h exp 0", bus.cpu_waitrequest); end
        checks++; if (bus.cpu_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_rdv_early got %0h exp 0", bus.cpu_readdatavalid); end
        @(negedge clk);
        bus.cpu_chipselect = 1'b0; bus.cpu_read = 1'b0;
        checks++; if (bus.cpu_readdatavalid !== 1'b1) begin errors++; $display("FAIL rd_rdv got %0h exp 1", bus.cpu_readdatavalid); end
        checks++; if (bus.cpu_readdata !== 32'd5) begin errors++; $display("FAIL rd_data got %0h exp 5", bus.cpu_readdata); end
        @(negedge clk);
        checks++; if (bus.cpu_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_rdv_after got %0h exp 0", bus.cpu_readdatavalid); end
        checks++; if (bus.cpu_readdata !== 32'd0) begin errors++; $display("FAIL rd_data_after got %0h exp 0", bus.cpu_readdata); end
    endtask

    task automatic test_back_to_back();
        int j;
        logic exp_wait;
        logic [DATA_W-1:0] exp_word;
        j = 0;
        @(negedge clk); arm = 1'b1; num_samples = 12'd8;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            arm = 1'b0; adc_valid = 1'b1; adc_data = 32'(100 + c - 1);
            bus.cpu_chipselect = 1'b1; bus.cpu_write = 1'b1; bus.cpu_read = 1'b0;
            bus.cpu_address = 11'(1000 + j); bus.cpu_writedata = 32'hC000_0000 + 32'(j); bus.cpu_byteenable = 4'hF;
            #1;
            exp_wait = ((c % 2) == 0);
            checks++; if (bus.cpu_waitrequest !== exp_wait) begin errors++; $display("FAIL b2b_wait cycle %0d got %0h exp %0h", c, bus.cpu_waitrequest, exp_wait); end
            if (c == 3) begin
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_early got %0h exp 0", overrun); end
            end
            if (c == 4) begin
                checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %0h exp 1", overrun); end
            end
            if (bus.cpu_waitrequest === 1'b0) j++;
        end
        @(negedge clk);
        adc_valid = 1'b0; bus.cpu_chipselect = 1'b0; bus.cpu_write = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_done done=%0h busy=%0h exp 1 0", done, busy); end
        checks++; if (wr_ptr !== 11'd8) begin errors++; $display("FAIL b2b_wr_ptr got %0d exp 8", wr_ptr); end
        checks++; if (j != 8) begin errors++; $display("FAIL b2b_cpu_writes got %0d exp 8", j); end
        for (int k = 0; k < 8; k++) begin
            exp_word = (k == 0) ? 32'd100 : 32'(100 + 2*k - 1);
            checks++; if (mem[k] !== exp_word) begin errors++; $display("FAIL b2b_adc_mem[%0d] got %0d exp %0d", k, mem[k], exp_word); end
            checks++; if (mem[1000+k] !== 32'hC000_0000 + 32'(k)) begin errors++; $display("FAIL b2b_cpu_mem[%0d] got %0h exp %0h", 1000+k, mem[1000+k], 32'hC000_0000 + 32'(k)); end
        end
    endtask

    task automatic test_wrap();
        int start;
        start = wr_count;
        @(negedge clk); arm = 1'b1; num_samples = 12'd0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); arm = 1'b0; adc_valid = 1'b1; adc_data = 32'(i);
        end
        @(negedge clk); adc_valid = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wrap_pre done=%0h busy=%0h exp 0 1", done, busy); end
        checks++; if (wr_ptr !== 11'd2047) begin errors++; $display("FAIL wrap_pre_ptr got %0d exp 2047", wr_ptr); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wrap_done done=%0h busy=%0h exp 1 0", done, busy); end
        checks++; if (wr_ptr !== 11'd0) begin errors++; $display("FAIL wrap_ptr got %0d exp 0", wr_ptr); end
        checks++; if (wr_count - start != 2048) begin errors++; $display("FAIL wrap_writes got %0d exp 2048", wr_count - start); end
        checks++; if (mem[0] !== 32'd0 || mem[2047] !== 32'd2047) begin errors++; $display("FAIL wrap_mem got %0d %0d exp 0 2047", mem[0], mem[2047]); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL wrap_overrun got %0h exp 0", overrun); end
    endtask

    task automatic test_abort();
        int start;
        @(negedge clk); arm = 1'b1; num_samples = 12'd8;
        @(negedge clk); arm = 1'b0; adc_valid = 1'b1; adc_data = 32'd200;
        @(negedge clk); adc_valid = 1'b0; abort = 1'b1; arm = 1'b1;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %0h exp 1", busy); end
        @(negedge clk); abort = 1'b0; arm = 1'b0;
        start = wr_count;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0h exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %0h exp 0", done); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); adc_valid = 1'b1; adc_data = 32'(300 + i);
        end
        @(negedge clk); adc_valid = 1'b0;
        @(negedge clk);
        checks++; if (wr_count != start) begin errors++; $display("FAIL abort_writes got %0d exp %0d", wr_count, start); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL abort_flags busy=%0h done=%0h ovr=%0h exp 0 0 0", busy, done, overrun); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); arm = 1'b1; num_samples = 12'd8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); arm = 1'b0; adc_valid = 1'b1; adc_data = 32'(400 + i);
        end
        bus.cpu_chipselect = 1'b1; bus.cpu_read = 1'b1; bus.cpu_address = 11'd3;
        #1;
        checks++; if (busy !== 1'b1 || wr_ptr !== 11'd2) begin errors++; $display("FAIL rst_mid_pre busy=%0h ptr=%0d exp 1 2", busy, wr_ptr); end
        checks++; if (bus.cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_mid_grant wait=%0h exp 0", bus.cpu_waitrequest); end
        #1 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0 || wr_ptr !== 11'd0)
            begin errors++; $display("FAIL rst_mid_state busy=%0h done=%0h ovr=%0h ptr=%0d exp 0 0 0 0", busy, done, overrun, wr_ptr); end
        checks++; if (bus.cpu_readdatavalid !== 1'b0 || bus.cpu_waitrequest !== 1'b0 || bus.cpu_readdata !== 32'd0)
            begin errors++; $display("FAIL rst_mid_cpu rdv=%0h wait=%0h data=%0h exp 0 0 0", bus.cpu_readdatavalid, bus.cpu_waitrequest, bus.cpu_readdata); end
        checks++; if (bus.mem_chipselect !== 1'b0 || bus.mem_write !== 1'b0)
            begin errors++; $display("FAIL rst_mid_mem cs=%0h we=%0h exp 0 0", bus.mem_chipselect, bus.mem_write); end
        @(negedge clk);
        bus.cpu_chipselect = 1'b0; bus.cpu_read = 1'b0; adc_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.cpu_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_mid_rdv_after cycle %0d got %0h exp 0", i, bus.cpu_readdatavalid); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got %0h exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_capture8();
        test_cpu_read();
        test_back_to_back();
        test_wrap();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
